// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the parameterised binary-to-BCD converter:
//   - state_t        : converter FSM states (IDLE, CONVERT)
//   - DIGIT_W        : bits per BCD digit
//   - ADD3_THRESHOLD : digit value from which the +3 correction applies
//   - ADD3_VALUE     : correction added to a digit at or above the threshold
//   - min_digits()   : smallest digit count able to hold 2^bin_w - 1
// -----------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_t;

   localparam int unsigned DIGIT_W        = 4;
   localparam int unsigned ADD3_THRESHOLD = 5;
   localparam int unsigned ADD3_VALUE     = 3;

   // Smallest d with 10^d > 2^bin_w - 1, i.e. ceil(bin_w * log10(2)).
   // 2^bin_w is never a power of ten for bin_w >= 1, so the ceiling equals
   // floor(bin_w * log10(2)) + 1. log10(2) is taken as 0.30103, which is
   // exact enough for any width this block will realistically see.
   function automatic int unsigned min_digits(input int unsigned bin_w);
      longint unsigned scaled;
      scaled = longint'(bin_w) * 64'd30103;
      return 32'(scaled / 64'd100000) + 32'd1;
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_in  : BCD digit before correction
//   digit_out : corrected digit (digit_in + 3 if digit_in >= 5, else digit_in)
// -----------------------------------------------------------------------------
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= DIGIT_W'(ADD3_THRESHOLD)) begin
         digit_out = digit_in + DIGIT_W'(ADD3_VALUE);
      end
   end

endmodule : bcd_digit_adjust

// File: rtl/binary_to_bcd_converter_param.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_converter_param
// Sequential shift-and-add-3 (double dabble) binary-to-BCD converter. One input
// bit is consumed per clock; a conversion takes BIN_W cycles in CONVERT.
//
// Parameters:
//   BIN_W  : binary input width (>= 2)
//   DIGITS : number of BCD digits (10^DIGITS must exceed 2^BIN_W - 1)
//
// Ports:
//   clk               : clock, all state changes on the rising edge
//   reset             : asynchronous, active-high reset
//   start_conversion  : request, sampled only in IDLE
//   binary_data       : operand, captured on the edge that accepts start
//   busy              : high while converting
//   end_of_conversion : one-cycle pulse when bcd_data is updated
//   bcd_data          : result, digit 0 in [3:0], held until next completion
//   bcd_sign          : sign of the last result
//
// Build option:
//   BCD_SIGNED_EN : when defined, binary_data is two's complement; the
//                   magnitude is converted and bcd_sign reports the operand
//                   MSB. When undefined, bcd_sign is tied to 0.
// -----------------------------------------------------------------------------
module binary_to_bcd_converter_param
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_conversion,
   input  logic [BIN_W-1:0]      binary_data,
   output logic                  busy,
   output logic                  end_of_conversion,
   output logic [4*DIGITS-1:0]   bcd_data,
   output logic                  bcd_sign
);

   localparam int unsigned BCD_W   = DIGIT_W * DIGITS;
   localparam int unsigned SR_W    = BIN_W + BCD_W;
   localparam int unsigned COUNT_W = $clog2(BIN_W);

   // Elaboration-time configuration checks.
   if (BIN_W < 2) begin : g_bad_bin_w
      $error("binary_to_bcd_converter_param: BIN_W must be at least 2");
   end
   if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
      $error("binary_to_bcd_converter_param: DIGITS too small for BIN_W");
   end

   state_t               state;
   state_t               next_state;
   logic                 accept;
   logic                 last_step;

   logic [SR_W-1:0]      shift_reg;
   logic [BCD_W-1:0]     adj_digits;
   logic [SR_W-1:0]      adjusted;
   logic [SR_W-1:0]      shifted;
   logic [COUNT_W-1:0]   count;
   logic [BIN_W-1:0]     magnitude;

   // ---------------------------------------------------------------------------
   // Operand conditioning
   // ---------------------------------------------------------------------------
`ifdef BCD_SIGNED_EN
   logic op_sign;
   logic sign_cap;

   assign op_sign = binary_data[BIN_W-1];
   // Negation on BIN_W bits: the most negative value maps to 2^(BIN_W-1).
   assign magnitude = op_sign ? (~binary_data + BIN_W'(1)) : binary_data;
`else
   assign magnitude = binary_data;
`endif

   // ---------------------------------------------------------------------------
   // Digit corrections, all evaluated in parallel from the registered value
   // ---------------------------------------------------------------------------
   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      bcd_digit_adjust u_adjust (
         .digit_in  (shift_reg[BIN_W + d*DIGIT_W +: DIGIT_W]),
         .digit_out (adj_digits[d*DIGIT_W +: DIGIT_W])
      );
   end

   always_comb begin
      adjusted = {adj_digits, shift_reg[BIN_W-1:0]};
      shifted  = adjusted << 1;
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start_conversion) begin
               accept     = 1'b1;
               next_state = CONVERT;
            end
         end
         CONVERT: begin
            busy = 1'b1;
            if (count == COUNT_W'(BIN_W - 1)) begin
               last_step  = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg         <= '0;
         count             <= '0;
         bcd_data          <= '0;
         end_of_conversion <= 1'b0;
      end else begin
         end_of_conversion <= 1'b0;
         if (accept) begin
            shift_reg <= {{BCD_W{1'b0}}, magnitude};
            count     <= '0;
         end else if (busy) begin
            shift_reg <= shifted;
            count     <= count + COUNT_W'(1);
            if (last_step) begin
               bcd_data          <= shifted[SR_W-1 -: BCD_W];
               end_of_conversion <= 1'b1;
            end
         end
      end
   end

`ifdef BCD_SIGNED_EN
   // Sign is captured with the operand and only published with the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sign_cap <= 1'b0;
         bcd_sign <= 1'b0;
      end else begin
         if (accept) begin
            sign_cap <= op_sign;
         end
         if (last_step) begin
            bcd_sign <= sign_cap;
         end
      end
   end
`else
   assign bcd_sign = 1'b0;
`endif

endmodule : binary_to_bcd_converter_param

// File: tb/tb_binary_to_bcd_converter_param.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd_converter_param
// Bench for binary_to_bcd_converter_param: an 8-bit/3-digit instance checked
// every cycle against a decimal-arithmetic model, plus a 16-bit/5-digit
// instance checked with directed literals. Honours BCD_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd_converter_param;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 3;
   localparam int unsigned W2 = 16;
   localparam int unsigned D2 = 5;

`ifdef BCD_SIGNED_EN
   localparam logic [4*D-1:0]  E255  = 12'h001; localparam logic S255 = 1'b1;
   localparam logic [4*D-1:0]  E80   = 12'h128; localparam logic S80  = 1'b1;
   localparam logic [4*D2-1:0] E65535 = 20'h00001; localparam logic S65535 = 1'b1;
`else
   localparam logic [4*D-1:0]  E255  = 12'h255; localparam logic S255 = 1'b0;
   localparam logic [4*D-1:0]  E80   = 12'h128; localparam logic S80  = 1'b0;
   localparam logic [4*D2-1:0] E65535 = 20'h65535; localparam logic S65535 = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [W-1:0]    data = '0;
   logic            busy, eoc, sign;
   logic [4*D-1:0]  bcd;

   logic            start2 = 1'b0;
   logic [W2-1:0]   data2 = '0;
   logic            busy2, eoc2, sign2;
   logic [4*D2-1:0] bcd2;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;
   bit rec_en = 1'b0;
   int cyc = 0;
   int eoc_cycles[$];

   always #5 clk = ~clk;

   binary_to_bcd_converter_param #(.BIN_W(W), .DIGITS(D)) dut (
      .clk               (clk),
      .reset             (reset),
      .start_conversion  (start),
      .binary_data       (data),
      .busy              (busy),
      .end_of_conversion (eoc),
      .bcd_data          (bcd),
      .bcd_sign          (sign)
   );

   binary_to_bcd_converter_param #(.BIN_W(W2), .DIGITS(D2)) dut16 (
      .clk               (clk),
      .reset             (reset),
      .start_conversion  (start2),
      .binary_data       (data2),
      .busy              (busy2),
      .end_of_conversion (eoc2),
      .bcd_data          (bcd2),
      .bcd_sign          (sign2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // ---- behavioural model: decimal arithmetic + cycle countdown -------------
   function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
      logic [4*D-1:0] r;
      int unsigned    x;
      r = '0;
      x = v;
      for (int unsigned i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int unsigned mag_of(input int unsigned v);
`ifdef BCD_SIGNED_EN
      if (v >= (32'd1 << (W - 1))) return (32'd1 << W) - v;
`endif
      return v;
   endfunction

   function automatic logic sign_of(input int unsigned v);
`ifdef BCD_SIGNED_EN
      return v >= (32'd1 << (W - 1));
`else
      return 1'b0 & v[0];
`endif
   endfunction

   logic           m_busy = 1'b0;
   logic           m_eoc = 1'b0;
   logic [4*D-1:0] m_bcd = '0;
   logic           m_sign = 1'b0;
   logic           m_pend_sign = 1'b0;
   int unsigned    m_val = 0;
   int unsigned    m_left = 0;
   int             m_accepts = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_eoc  <= 1'b0;
         m_bcd  <= '0;
         m_sign <= 1'b0;
         m_left <= 0;
      end else begin
         m_eoc <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_eoc  <= 1'b1;
               m_bcd  <= to_bcd(m_val);
               m_sign <= m_pend_sign;
            end
            m_left <= m_left - 1;
         end else if (start) begin
            m_busy      <= 1'b1;
            m_left      <= W;
            m_val       <= mag_of(32'(data));
            m_pend_sign <= sign_of(32'(data));
            m_accepts   <= m_accepts + 1;
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---- per-cycle comparison -------------------------------------------------
   always @(posedge clk) begin
      #2;
      if (cmp_en) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("eoc", 64'(eoc), 64'(m_eoc));
         check("bcd", 64'(bcd), 64'(m_bcd));
         check("sign", 64'(sign), 64'(m_sign));
         if (rec_en && eoc) eoc_cycles.push_back(cyc);
      end
   end

   // ---- directed helpers ----------------------------------------------------
   task automatic wait_eoc(input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles && !seen; c++) begin
         @(posedge clk); #2;
         if (eoc) seen = 1'b1;
      end
      check("eoc_seen", 64'(seen), 64'd1);
   endtask

   task automatic run_one(input logic [W-1:0] v, input logic [4*D-1:0] exp_bcd,
                          input logic exp_sign);
      @(negedge clk); data = v; start = 1'b1;
      @(posedge clk); #2;
      check("busy_after_accept", 64'(busy), 64'd1);
      @(negedge clk); start = 1'b0; data = '0;
      for (int j = 1; j < int'(W); j++) begin
         @(posedge clk); #2;
         check("busy_mid", 64'(busy), 64'd1);
         check("eoc_early", 64'(eoc), 64'd0);
      end
      @(posedge clk); #2;
      check("eoc_latency", 64'(eoc), 64'd1);
      check("busy_done", 64'(busy), 64'd0);
      check("bcd_literal", 64'(bcd), 64'(exp_bcd));
      check("sign_literal", 64'(sign), 64'(exp_sign));
      @(posedge clk); #2;
      check("eoc_one_cycle", 64'(eoc), 64'd0);
      check("bcd_hold", 64'(bcd), 64'(exp_bcd));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      bit got;
      int bad_gaps;

      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_eoc", 64'(eoc), 64'd0);
      check("rst_bcd", 64'(bcd), 64'd0);
      check("rst_sign", 64'(sign), 64'd0);
      check("rst_bcd16", 64'(bcd2), 64'd0);

      run_one(8'd255, E255, S255);
      run_one(8'h80, E80, S80);
      run_one(8'h7F, 12'h127, 1'b0);

      // Start and operand change mid-conversion are ignored.
      @(negedge clk); data = 8'd99; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; data = '0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; data = 8'd55;
      @(negedge clk); start = 1'b0; data = '0;
      wait_eoc(20);
      check("ignore_bcd", 64'(bcd), 64'h099);
      check("ignore_sign", 64'(sign), 64'd0);
      @(posedge clk); #2;
      check("ignore_no_restart", 64'(busy), 64'd0);

      // Reset in the middle of a conversion.
      @(negedge clk); data = 8'd200; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_bcd", 64'(bcd), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_eoc", 64'(eoc), 64'd0);
      @(negedge clk); reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         check("midrst_no_eoc", 64'(eoc), 64'd0);
      end
      run_one(8'd7, 12'h007, 1'b0);

      // Exhaustive back-to-back with start held high.
      rec_en = 1'b1;
      acc0 = m_accepts;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         data = 8'(i); start = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (m_accepts != acc0) got = 1'b1;
         end
         check("b2b_accepted", 64'(got), 64'd1);
         acc0 = m_accepts;
         @(negedge clk);
      end
      start = 1'b0;
      wait_eoc(20);
      rec_en = 1'b0;
      check("b2b_results", 64'(eoc_cycles.size()), 64'd256);
      bad_gaps = 0;
      for (int i = 1; i < eoc_cycles.size(); i++) begin
         if (eoc_cycles[i] - eoc_cycles[i-1] != int'(W) + 1) bad_gaps++;
      end
      check("b2b_spacing", 64'(bad_gaps), 64'd0);

      // 16-bit / 5-digit instance.
      @(negedge clk); data2 = 16'hFFFF; start2 = 1'b1;
      @(posedge clk);
      @(negedge clk); start2 = 1'b0; data2 = '0;
      for (int j = 1; j < int'(W2); j++) begin
         @(posedge clk); #2;
         check("w16_busy", 64'(busy2), 64'd1);
         check("w16_eoc_early", 64'(eoc2), 64'd0);
      end
      @(posedge clk); #2;
      check("w16_eoc", 64'(eoc2), 64'd1);
      check("w16_bcd", 64'(bcd2), 64'(E65535));
      check("w16_sign", 64'(sign2), 64'(S65535));
      check("w16_busy_done", 64'(busy2), 64'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_binary_to_bcd_converter_param
